// File: rtl/apu_rr_arbiter_if.sv
// Bus bundles for the APU round-robin arbiter: a core-facing bundle (vectorised per core)
// and an FPU-facing bundle (single channel). The arbiter is the slave of the cores and the master of the FPU.
interface apu_core_if #(
    parameter int NB_CORES        = 4,
    parameter int CORE_ID_WIDTH   = 5,
    parameter int PAYLOAD_WIDTH   = 85,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5
);
    logic [NB_CORES-1:0]                     req;
    logic [NB_CORES-1:0]                     gnt;
    logic [NB_CORES-1:0][CORE_ID_WIDTH-1:0]  id;
    logic [NB_CORES-1:0][PAYLOAD_WIDTH-1:0]  payload;
    logic [NB_CORES-1:0]                     rvalid;
    logic [DATA_WIDTH-1:0]                   rdata;
    logic [FLAGS_OUT_WIDTH-1:0]              rflags;
    logic [CORE_ID_WIDTH-1:0]                rid;

    modport master (output req, id, payload, input gnt, rvalid, rdata, rflags, rid);
    modport slave  (input req, id, payload, output gnt, rvalid, rdata, rflags, rid);
endinterface

interface apu_fpu_if #(
    parameter int ID_WIDTH        = 9,
    parameter int PAYLOAD_WIDTH   = 85,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5
);
    logic                        req;
    logic                        gnt;
    logic [ID_WIDTH-1:0]         id;
    logic [PAYLOAD_WIDTH-1:0]    payload;
    logic                        rvalid;
    logic [DATA_WIDTH-1:0]       rdata;
    logic [FLAGS_OUT_WIDTH-1:0]  rflags;
    logic [ID_WIDTH-1:0]         rid;

    modport master (output req, id, payload, input gnt, rvalid, rdata, rflags, rid);
    modport slave  (input req, id, payload, output gnt, rvalid, rdata, rflags, rid);
endinterface

// File: rtl/apu_rr_arbiter.sv
// Round-robin arbiter funnelling NB_CORES request streams into one registered FPU request slot
// and demultiplexing FPU results back by tag. Define APU_RR_ARBITER_RESP_REG_EN to register the response path.
module apu_rr_arbiter #(
    parameter int NB_CORES        = 4,
    parameter int CORE_ID_WIDTH   = 5,
    parameter int ID_WIDTH        = 9,
    parameter int PAYLOAD_WIDTH   = 85,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    apu_core_if.slave core,
    apu_fpu_if.master fpu
);
    localparam int IDX_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int RIDX_W = ID_WIDTH - CORE_ID_WIDTH;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NB_CORES - 1);

    if (NB_CORES < 2) begin : g_bad_nb_cores
        $error("apu_rr_arbiter: NB_CORES must be at least 2");
    end
    if (ID_WIDTH < IDX_W + CORE_ID_WIDTH) begin : g_bad_id_width
        $error("apu_rr_arbiter: ID_WIDTH too small for core index plus core tag");
    end

    logic                      can_accept_s;
    logic                      gnt_found_s;
    logic [IDX_W-1:0]          gnt_idx_s;
    logic [IDX_W-1:0]          cand_s;
    logic [NB_CORES-1:0]       gnt_s;

    logic                      valid_r;
    logic [ID_WIDTH-1:0]       id_r;
    logic [PAYLOAD_WIDTH-1:0]  payload_r;
    logic [IDX_W-1:0]          last_r;

    logic [RIDX_W-1:0]         resp_idx_s;
    logic [NB_CORES-1:0]       rvalid_s;

    // Round-robin search: first requester strictly after the last granted index, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int i = 1; i <= NB_CORES; i++) begin
            cand_s = IDX_W'((int'(last_r) + i) % NB_CORES);
            if (!gnt_found_s && core.req[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_idx_s   = gnt_idx_s;
            end
        end
    end

    // Grant only when the slot is empty or draining this cycle; held low while in reset.
    always_comb begin
        can_accept_s = rst_n & (~valid_r | fpu.gnt);
        gnt_s        = '0;
        if (can_accept_s && gnt_found_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    assign core.gnt = gnt_s;

    // One-entry request slot; refill and drain may happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            id_r      <= '0;
            payload_r <= '0;
            last_r    <= LAST_RST;
        end else if (can_accept_s) begin
            valid_r <= gnt_found_s;
            if (gnt_found_s) begin
                id_r      <= ID_WIDTH'({gnt_idx_s, core.id[gnt_idx_s]});
                payload_r <= core.payload[gnt_idx_s];
                last_r    <= gnt_idx_s;
            end
        end
    end

    assign fpu.req     = valid_r;
    assign fpu.id      = id_r;
    assign fpu.payload = payload_r;

    // Decode the core-index field of the result tag; out-of-range indices select nobody.
    always_comb begin
        resp_idx_s = fpu.rid[ID_WIDTH-1:CORE_ID_WIDTH];
        rvalid_s   = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            if (rst_n && fpu.rvalid && (resp_idx_s == RIDX_W'(k))) begin
                rvalid_s[k] = 1'b1;
            end else begin
                rvalid_s[k] = 1'b0;
            end
        end
    end

`ifdef APU_RR_ARBITER_RESP_REG_EN
    logic [NB_CORES-1:0]        rvalid_r;
    logic [DATA_WIDTH-1:0]      rdata_r;
    logic [FLAGS_OUT_WIDTH-1:0] rflags_r;
    logic [CORE_ID_WIDTH-1:0]   rid_r;

    // One-cycle response pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= '0;
            rdata_r  <= '0;
            rflags_r <= '0;
            rid_r    <= '0;
        end else begin
            rvalid_r <= rvalid_s;
            rdata_r  <= fpu.rdata;
            rflags_r <= fpu.rflags;
            rid_r    <= fpu.rid[CORE_ID_WIDTH-1:0];
        end
    end

    assign core.rvalid = rvalid_r;
    assign core.rdata  = rdata_r;
    assign core.rflags = rflags_r;
    assign core.rid    = rid_r;
`else
    assign core.rvalid = rvalid_s;
    assign core.rdata  = fpu.rdata;
    assign core.rflags = fpu.rflags;
    assign core.rid    = fpu.rid[CORE_ID_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_apu_rr_arbiter.sv
// Scoreboard bench for apu_rr_arbiter: a transaction-level model predicts grants, FPU transfers
// and core responses into queues; an independent monitor pops and compares against the DUT.
module tb_apu_rr_arbiter;
    localparam int NB  = 4;
    localparam int CIW = 5;
    localparam int IW  = 9;
    localparam int PW  = 85;
    localparam int DW  = 32;
    localparam int FW  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apu_core_if #(.NB_CORES(NB), .CORE_ID_WIDTH(CIW), .PAYLOAD_WIDTH(PW),
                  .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW)) core_bus ();
    apu_fpu_if  #(.ID_WIDTH(IW), .PAYLOAD_WIDTH(PW),
                  .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW)) fpu_bus ();

    apu_rr_arbiter #(.NB_CORES(NB), .CORE_ID_WIDTH(CIW), .ID_WIDTH(IW), .PAYLOAD_WIDTH(PW),
                     .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_bus),
        .fpu   (fpu_bus)
    );

    typedef struct { logic [IW-1:0] id; logic [PW-1:0] payload; } xfer_t;
    typedef struct { logic [NB-1:0] onehot; logic [CIW-1:0] tag; logic [DW-1:0] data; logic [FW-1:0] flags; } resp_t;

    int checks = 0;
    int errors = 0;
    logic [NB-1:0] gnt_q [$];
    xfer_t         xfer_q[$];
    resp_t         resp_q[$];

    // Reference model state: one held request plus the last granted core.
    bit             m_valid = 1'b0;
    int             m_last  = NB - 1;
    logic [IW-1:0]  m_id;
    logic [PW-1:0]  m_pl;

    logic [NB-1:0]           n_req   = '0;
    logic                    n_fgnt  = 1'b0;
    logic                    n_rv    = 1'b0;
    logic [IW-1:0]           n_rid   = '0;
    logic [NB-1:0][CIW-1:0]  n_id    = '0;
    logic [NB-1:0][PW-1:0]   n_pl    = '0;
    logic [DW-1:0]           n_rdata = '0;
    logic [FW-1:0]           n_rflags = '0;

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_data();
        for (int c = 0; c < NB; c++) begin
            logic [95:0] w;
            w = {$urandom, $urandom, $urandom};
            n_id[c] = CIW'($urandom);
            n_pl[c] = w[PW-1:0];
        end
        n_rdata  = $urandom;
        n_rflags = FW'($urandom);
    endtask

    // Apply one cycle of stimulus at the falling edge and predict everything it should cause.
    task automatic step();
        int            idx;
        int            g;
        bit            can;
        logic [NB-1:0] eg;
        xfer_t         x;
        resp_t         r;
        @(negedge clk);
        core_bus.req     = n_req;
        core_bus.id      = n_id;
        core_bus.payload = n_pl;
        fpu_bus.gnt      = n_fgnt;
        fpu_bus.rvalid   = n_rv;
        fpu_bus.rid      = n_rid;
        fpu_bus.rdata    = n_rdata;
        fpu_bus.rflags   = n_rflags;
        #1;
        can = !m_valid || n_fgnt;
        g   = -1;
        eg  = '0;
        if (can) begin
            for (int off = 1; off <= NB; off++) begin
                idx = (m_last + off) % NB;
                if (n_req[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        gnt_q.push_back(eg);
        if (m_valid && n_fgnt) begin
            x.id = m_id;
            x.payload = m_pl;
            xfer_q.push_back(x);
        end
        if (can) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_id    = IW'(g * (2 ** CIW) + int'(n_id[g]));
                m_pl    = n_pl[g];
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        idx = int'(n_rid) / (2 ** CIW);
        if (n_rv && idx < NB) begin
            r.onehot = NB'(1 << idx);
            r.tag    = CIW'(int'(n_rid) % (2 ** CIW));
            r.data   = n_rdata;
            r.flags  = n_rflags;
            resp_q.push_back(r);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        core_bus.req   = '0;
        fpu_bus.gnt    = 1'b0;
        fpu_bus.rvalid = 1'b0;
        #1;
        chk("rst_mid_fpu_req", fpu_bus.req, 1'b0);
        chk("rst_mid_gnt", core_bus.gnt, 4'b0000);
        gnt_q.delete();
        xfer_q.delete();
        resp_q.delete();
        m_valid = 1'b0;
        m_last  = NB - 1;
        n_req   = '0;
        n_fgnt  = 1'b0;
        n_rv    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare whatever the DUT presents against the queued predictions.
    always @(negedge clk) begin
        logic [NB-1:0] eg;
        xfer_t x;
        resp_t r;
        #2;
        if (rst_n) begin
            if (gnt_q.size() > 0) begin
                eg = gnt_q.pop_front();
                chk("core_gnt", core_bus.gnt, eg);
            end else if (core_bus.gnt !== '0) begin
                chk("core_gnt_idle", core_bus.gnt, 4'b0000);
            end
            if (fpu_bus.req && fpu_bus.gnt) begin
                if (xfer_q.size() > 0) begin
                    x = xfer_q.pop_front();
                    chk("fpu_id", fpu_bus.id, x.id);
                    chk("fpu_payload", fpu_bus.payload, x.payload);
                end else begin
                    chk("fpu_spurious_xfer", fpu_bus.req, 1'b0);
                end
            end
            if (|core_bus.rvalid) begin
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    chk("core_rvalid", core_bus.rvalid, r.onehot);
                    chk("core_rid", core_bus.rid, r.tag);
                    chk("core_rdata", core_bus.rdata, r.data);
                    chk("core_rflags", core_bus.rflags, r.flags);
                end else begin
                    chk("core_spurious_rvalid", core_bus.rvalid, 4'b0000);
                end
            end
        end
    end

    task automatic rand_cycles(input int n);
        int idx;
        repeat (n) begin
            rand_data();
            n_req  = NB'($urandom);
            n_fgnt = ($urandom_range(0, 3) != 0);
            n_rv   = 1'($urandom_range(0, 1));
            idx    = $urandom_range(0, 7);
            n_rid  = IW'(idx * (2 ** CIW) + $urandom_range(0, 31));
            step();
        end
    endtask

    initial begin
        core_bus.req     = '0;
        core_bus.id      = '0;
        core_bus.payload = '0;
        fpu_bus.gnt      = 1'b0;
        fpu_bus.rvalid   = 1'b0;
        fpu_bus.rid      = '0;
        fpu_bus.rdata    = '0;
        fpu_bus.rflags   = '0;
        #12;
        chk("rst_fpu_req", fpu_bus.req, 1'b0);
        chk("rst_fpu_id", fpu_bus.id, 9'h000);
        chk("rst_fpu_payload", fpu_bus.payload, 85'h0);
        chk("rst_core_gnt", core_bus.gnt, 4'b0000);
        chk("rst_core_rvalid", core_bus.rvalid, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // All cores requesting with the FPU always ready: strict rotation from core 0.
        n_req  = 4'b1111;
        n_fgnt = 1'b1;
        n_rv   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
            chk("rr_grant", core_bus.gnt, 4'b0001 << rr_exp[i]);
            if (i > 0) chk("rr_fpu_index", fpu_bus.id[IW-1:CIW], 4'(rr_exp[i-1]));
        end
        n_req = 4'b0000;
        step();

        // Stalled FPU: request held stable and no further grants.
        rand_data();
        n_id[2] = 5'h1A;
        n_req   = 4'b0100;
        n_fgnt  = 1'b1;
        step();
        chk("stall_first_grant", core_bus.gnt, 4'b0100);
        n_req  = 4'b1111;
        n_fgnt = 1'b0;
        repeat (3) begin
            rand_data();
            step();
            chk("stall_fpu_req", fpu_bus.req, 1'b1);
            chk("stall_fpu_id", fpu_bus.id, 9'h05A);
            chk("stall_core_gnt", core_bus.gnt, 4'b0000);
        end
        n_req  = 4'b0000;
        n_fgnt = 1'b1;
        step();

        // Response routing and out-of-range drop.
        n_rv  = 1'b1;
        n_rid = 9'h073;
        step();
`ifdef APU_RR_ARBITER_RESP_REG_EN
        n_rv = 1'b0;
        step();
`endif
        chk("resp_rvalid_core3", core_bus.rvalid, 4'b1000);
        chk("resp_rid", core_bus.rid, 5'h13);
        chk("resp_rdata", core_bus.rdata, n_rdata);
        n_rv  = 1'b1;
        n_rid = 9'h080;
        step();
`ifdef APU_RR_ARBITER_RESP_REG_EN
        n_rv = 1'b0;
        step();
`endif
        chk("resp_drop_idx4", core_bus.rvalid, 4'b0000);
        n_rv = 1'b0;

        rand_cycles(1500);

        // Reset while a request is held must discard it.
        n_req  = 4'b0010;
        n_fgnt = 1'b0;
        n_rv   = 1'b0;
        repeat (2) step();
        chk("pre_rst_fpu_req", fpu_bus.req, 1'b1);
        do_reset();
        n_req = 4'b0000;
        repeat (3) begin
            n_fgnt = 1'($urandom_range(0, 1));
            step();
            chk("post_rst_fpu_req", fpu_bus.req, 1'b0);
        end

        rand_cycles(300);

        n_req  = 4'b0000;
        n_fgnt = 1'b1;
        n_rv   = 1'b0;
        repeat (3) step();
        @(negedge clk);
        #3;
        chk("xfer_queue_drained", 128'(xfer_q.size()), 128'd0);
        chk("resp_queue_drained", 128'(resp_q.size()), 128'd0);
        chk("gnt_queue_drained", 128'(gnt_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apu_rr_arbiter.md
APU_RR_ARBITER -- requirements
Module: apu_rr_arbiter

Interface
REQ-001 SHALL have parameter NB_CORES, default 4: number of requesting cores, at least 2.
REQ-002 SHALL have parameter CORE_ID_WIDTH, default 5: per-core transaction tag width.
REQ-003 SHALL have parameter ID_WIDTH, default 9: FPU tag width; SHALL be at least $clog2(NB_CORES)+CORE_ID_WIDTH, otherwise elaboration error.
REQ-004 SHALL have parameter PAYLOAD_WIDTH, default 85: packed {operands, op, flags} request payload (2x32+6+15).
REQ-005 SHALL have parameter DATA_WIDTH, default 32: result width.
REQ-006 SHALL have parameter FLAGS_OUT_WIDTH, default 5: status flag width.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 core_req_i  in  NB_CORES  per-core request valid.
REQ-010 core_gnt_o  out  NB_CORES  per-core grant; request accepted when req&gnt.
REQ-011 core_id_i  in  NB_CORES x CORE_ID_WIDTH  per-core tag.
REQ-012 core_payload_i  in  NB_CORES x PAYLOAD_WIDTH  per-core packed operands/op/flags.
REQ-013 core_rvalid_o  out  NB_CORES  one-hot response valid.
REQ-014 core_rdata_o  out  DATA_WIDTH  response result, shared by all cores.
REQ-015 core_rflags_o  out  FLAGS_OUT_WIDTH  response status, shared.
REQ-016 core_rid_o  out  CORE_ID_WIDTH  response core tag, shared.
REQ-017 fpu_req_o  out  1  request valid to FPU wrapper.
REQ-018 fpu_gnt_i  in  1  FPU ready; transfer when fpu_req_o&fpu_gnt_i.
REQ-019 fpu_id_o  out  ID_WIDTH  {zero pad, core index, core tag}.
REQ-020 fpu_payload_o  out  PAYLOAD_WIDTH  registered payload.
REQ-021 fpu_rvalid_i  in  1  FPU result valid; no backpressure, always accepted.
REQ-022 fpu_rdata_i / fpu_rflags_i / fpu_rid_i  in  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  FPU result, status, tag.

Function
REQ-023 SHALL hold a one-entry request register (valid_q, id_q, payload_q); fpu_req_o=valid_q, fpu_id_o=id_q, fpu_payload_o=payload_q.
REQ-024 Register SHALL accept a new request when valid_q=0 or fpu_gnt_i=1 (same-cycle drain and refill permitted).
REQ-025 At most one core_gnt_o bit SHALL be high per cycle, and only when the register can accept and that core requests.
REQ-026 Arbitration SHALL be round-robin: search starts at index last_q+1 mod NB_CORES; last_q updates to the granted index only on a grant.
REQ-027 Grant cycle T: at edge T+1, valid_q=1, id_q={granted index, core_id_i}, payload_q=core_payload_i; no FPU request appears in cycle T.
REQ-028 valid_q SHALL clear when fpu_gnt_i&valid_q and no new grant; id_q/payload_q SHALL be stable while fpu_req_o=1 and fpu_gnt_i=0.
REQ-029 Sustained throughput SHALL be one request per cycle while fpu_gnt_i=1.
REQ-030 Response: core_rvalid_o[k] SHALL be set for k=fpu_rid_i core-index field; core_rid_o=fpu_rid_i core-tag field; rdata/rflags forwarded unmodified.
REQ-031 A response whose index field is >= NB_CORES SHALL be dropped (all core_rvalid_o low).
REQ-032 A response and a request in the same cycle SHALL be handled independently.

Reset
REQ-033 On rst_n low: valid_q=0, id_q=0, payload_q=0, last_q=NB_CORES-1 (core 0 highest priority first), core_gnt_o=0, core_rvalid_o=0, core response registers 0.
REQ-034 Reset mid-transfer SHALL discard the held request; no spurious fpu_req_o after release.

Configuration
REQ-035 Macro APU_RR_ARBITER_RESP_REG_EN: when defined, the response path SHALL be registered (core_rvalid_o and data one cycle after fpu_rvalid_i).
REQ-036 When undefined, the response path SHALL be combinational, with zero latency from fpu_rvalid_i.

Verification
REQ-037 Reset, then core_req_i=4'b1111 and fpu_gnt_i=1 held -> grants 0,1,2,3,0 on consecutive cycles; fpu_id_o core-index field follows one cycle later.
REQ-038 core 2 request with tag 5'h1A, fpu_gnt_i=0 for 3 cycles -> fpu_req_o held, fpu_id_o=9'h05A stable, core_gnt_o=0 for all cores until fpu_gnt_i=1.
REQ-039 fpu_rvalid_i=1, fpu_rid_i=9'h073 -> core_rvalid_o=4'b1000 and core_rid_o=5'h13 (next cycle with RESP_REG_EN, same cycle without).
REQ-040 fpu_rid_i index field 4 with NB_CORES=4 (e.g. 9'h080) -> core_rvalid_o=0.
REQ-041 rst_n low while valid_q=1 -> fpu_req_o=0 immediately; after release with core_req_i=0, fpu_req_o stays 0.
